vending_controller: RTL and testbench
=====================================

VENDING_CONTROLLER -- requirements
Module: vending_controller

Interface
REQ-001 Param NUM_SLOTS, default 9, number of selectable product slots (2..16).
REQ-002 Param CREDIT_W, default 12, credit/price width in cents.
REQ-003 Param STOCK_W, default 4, per-slot stock counter width.
REQ-004 Param MAX_CREDIT, default 1000, credit ceiling in cents (multiple of 5).
REQ-005 Param PRICE_HOLD, default 50000000, cycles a selected price stays on display.
REQ-006 clk  in  1  system clock; all state changes on its rising edge.
REQ-007 resetN  in  1  reset, asynchronous, active-low.
REQ-008 coinValid  in  1  one-cycle pulse: coin/bill inserted.
REQ-009 coinCode  in  3  0=5c, 1=10c, 2=25c, 3=50c, 4=100c, 5=500c, 6..7 invalid.
REQ-010 select  in  NUM_SLOTS  one-hot slot request pulse.
REQ-011 cancel  in  1  pulse: return all credit.
REQ-012 cfgWe, cfgAddr[$clog2(NUM_SLOTS)], cfgPrice[CREDIT_W], cfgStock[STOCK_W]  in  slot price/stock load port.
REQ-013 changeAck  in  1  dispenser accepted the presented change coin.
REQ-014 credit  out  CREDIT_W  current credit.
REQ-015 dispValue  out  CREDIT_W  display value; dispIsPrice  out  1  high while a price is shown.
REQ-016 affordMask, soldOutMask  out  NUM_SLOTS  per slot: price<=credit and stock>0; stock==0.
REQ-017 vendValid  out  1  one-cycle vend pulse; vendSlot  out  $clog2(NUM_SLOTS)  vended index.
REQ-018 changeValid  out  1, changeCoin  out  3  change coin offered (codes 0..4 only).
REQ-019 coinReject  out  1  one-cycle pulse: inserted coin returned, not credited.
REQ-020 busy  out  1  high in VEND or CHANGE.

Function
REQ-021 FSM states IDLE, VEND, CHANGE; IDLE holds any credit including zero.
REQ-022 IDLE, coinValid, valid code, credit+value<=MAX_CREDIT: credit += value next cycle.
REQ-023 Coin with invalid code, overflow past MAX_CREDIT, or arriving in VEND/CHANGE: coinReject pulse next cycle, credit unchanged.
REQ-024 IDLE, select one-hot, stock>0, price<=credit: go VEND; multi-hot or zero select ignored.
REQ-025 IDLE, select valid but unaffordable or sold out: dispValue=price, dispIsPrice=1 for PRICE_HOLD cycles, then reverts to credit; new select restarts hold.
REQ-026 VEND (exactly one cycle): vendValid=1, vendSlot=index, stock decremented, credit -= price; next CHANGE if credit>0 else IDLE.
REQ-027 IDLE, cancel, credit>0: go CHANGE; cancel with credit 0 ignored.
REQ-028 CHANGE: changeValid=1, changeCoin=largest of 100/50/25/10/5 <= credit (500c never returned); held stable until changeAck.
REQ-029 changeValid & changeAck: credit -= coin value same edge; credit 0 -> IDLE, changeValid low next cycle.
REQ-030 Same-cycle priority in IDLE: cancel > select > coin; the lower-priority coin is rejected per REQ-023.
REQ-031 cfgWe applied only in IDLE with credit 0; otherwise ignored; cfgAddr>=NUM_SLOTS ignored.
REQ-032 Stock never decrements below 0; credit never exceeds MAX_CREDIT or underflows.
REQ-033 dispValue = credit whenever dispIsPrice=0; a coin accept or vend clears price hold.

Reset
REQ-034 resetN low: state IDLE, credit 0, all prices and stock 0, hold counter 0.
REQ-035 Reset outputs: vendValid, changeValid, coinReject, busy, dispIsPrice 0; soldOutMask all 1; affordMask 0.
REQ-036 Reset mid-VEND or mid-CHANGE discards outstanding credit and change; no vend/change pulse follows.

Structure
REQ-037 Shared package holds coin code constants, coin value table, state encoding.
REQ-038 Sub-module change_picker: combinational credit -> largest returnable coin code/value.

Verification
REQ-039 Load slot0 price 65 stock 2; coins 25,25,10,5 then select slot0 -> vendValid slot0, credit 0, stock 1, no change.
REQ-040 Price 65; insert 100, select -> vend, then change 25 then 10, credit 0, IDLE.
REQ-041 Credit 995, MAX 1000; insert 10 -> coinReject, credit 995; insert 5 -> credit 1000.
REQ-042 Credit 20, select slot price 65 -> dispValue 65, dispIsPrice 1 for PRICE_HOLD cycles, then 20.
REQ-043 Credit 40, cancel with changeAck held low 5 cycles -> changeCoin 25 held stable; ack -> 10, then 5, IDLE.
REQ-044 Stock 1 vended, reselect same slot -> soldOutMask bit 1, no vend; resetN low mid-CHANGE -> credit 0, changeValid 0.

Source files
------------

// File: rtl/vending_controller_pkg.sv
// Shared definitions for the vending controller: coin codes, coin value
// table, FSM state encoding and small coin helpers.
package vending_controller_pkg;

   localparam logic [2:0] COIN_5   = 3'd0;
   localparam logic [2:0] COIN_10  = 3'd1;
   localparam logic [2:0] COIN_25  = 3'd2;
   localparam logic [2:0] COIN_50  = 3'd3;
   localparam logic [2:0] COIN_100 = 3'd4;
   localparam logic [2:0] COIN_500 = 3'd5;

   localparam int COIN_VAL_W = 10;

   // Value in cents, indexed by coin code (codes 6..7 have no entry).
   localparam logic [5:0][COIN_VAL_W-1:0] COIN_VALUE =
      {10'd500, 10'd100, 10'd50, 10'd25, 10'd10, 10'd5};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_VEND   = 2'd1,
      ST_CHANGE = 2'd2
   } vendState_t;

   function automatic logic coinIsValid(input logic [2:0] code);
      return code <= COIN_500;
   endfunction

   function automatic logic [COIN_VAL_W-1:0] coinValue(input logic [2:0] code);
      return coinIsValid(code) ? COIN_VALUE[code] : '0;
   endfunction

endpackage

// File: rtl/vending_controller_if.sv
// Host-side bundle of the vending controller: coin, selection, config,
// change handshake and status outputs.
interface vending_controller_if #(
   parameter int NUM_SLOTS = 9,
   parameter int CREDIT_W  = 12,
   parameter int STOCK_W   = 4
);
   localparam int IDX_W = $clog2(NUM_SLOTS);

   logic                 coinValid;
   logic [2:0]           coinCode;
   logic [NUM_SLOTS-1:0] select;
   logic                 cancel;
   logic                 cfgWe;
   logic [IDX_W-1:0]     cfgAddr;
   logic [CREDIT_W-1:0]  cfgPrice;
   logic [STOCK_W-1:0]   cfgStock;
   logic                 changeAck;

   logic [CREDIT_W-1:0]  credit;
   logic [CREDIT_W-1:0]  dispValue;
   logic                 dispIsPrice;
   logic [NUM_SLOTS-1:0] affordMask;
   logic [NUM_SLOTS-1:0] soldOutMask;
   logic                 vendValid;
   logic [IDX_W-1:0]     vendSlot;
   logic                 changeValid;
   logic [2:0]           changeCoin;
   logic                 coinReject;
   logic                 busy;

   modport master (
      output coinValid, coinCode, select, cancel, cfgWe, cfgAddr, cfgPrice,
             cfgStock, changeAck,
      input  credit, dispValue, dispIsPrice, affordMask, soldOutMask,
             vendValid, vendSlot, changeValid, changeCoin, coinReject, busy
   );

   modport slave (
      input  coinValid, coinCode, select, cancel, cfgWe, cfgAddr, cfgPrice,
             cfgStock, changeAck,
      output credit, dispValue, dispIsPrice, affordMask, soldOutMask,
             vendValid, vendSlot, changeValid, changeCoin, coinReject, busy
   );

endinterface

// File: rtl/vending_controller_change_picker.sv
// Combinational change picker: largest returnable coin (100c down to 5c)
// not exceeding the given amount. 500c is never paid out.
module change_picker
   import vending_controller_pkg::*;
#(
   parameter int CREDIT_W = 12
) (
   input  logic [CREDIT_W-1:0] amount,
   output logic [2:0]          coinCode,
   output logic [CREDIT_W-1:0] coinVal
);

   // Descending threshold compare; 5c is the floor when nothing larger fits.
   always_comb begin
      coinCode = COIN_5;
      if (amount >= CREDIT_W'(100))     coinCode = COIN_100;
      else if (amount >= CREDIT_W'(50)) coinCode = COIN_50;
      else if (amount >= CREDIT_W'(25)) coinCode = COIN_25;
      else if (amount >= CREDIT_W'(10)) coinCode = COIN_10;
      coinVal = CREDIT_W'(coinValue(coinCode));
   end

endmodule

// File: rtl/vending_controller.sv
// Vending controller: credit accumulation, slot price/stock table, vend
// sequencing, coin-by-coin change return and temporary price display.
module vending_controller
   import vending_controller_pkg::*;
#(
   parameter int NUM_SLOTS  = 9,
   parameter int CREDIT_W   = 12,
   parameter int STOCK_W    = 4,
   parameter int MAX_CREDIT = 1000,
   parameter int PRICE_HOLD = 50000000
) (
   input logic                 clk,
   input logic                 resetN,
   vending_controller_if.slave bus
);

   localparam int IDX_W  = $clog2(NUM_SLOTS);
   localparam int HOLD_W = $clog2(PRICE_HOLD + 1);
   localparam int SUM_W  = CREDIT_W + 1;
   localparam logic [CREDIT_W-1:0] FIVE = CREDIT_W'(5);

   vendState_t                          state;
   logic [CREDIT_W-1:0]                 credit;
   logic [NUM_SLOTS-1:0][CREDIT_W-1:0]  price;
   logic [NUM_SLOTS-1:0][STOCK_W-1:0]   stock;
   logic [HOLD_W-1:0]                   holdCnt;
   logic                                dispIsPrice;
   logic [CREDIT_W-1:0]                 dispPrice;
   logic                                vendValid;
   logic [IDX_W-1:0]                    vendSlot;
   logic                                coinReject;

   logic                isIdle, selOneHot, selAfford, cmdSel;
   logic                cancelGo, vendGo, showPrice, coinAccept, cfgGo;
   logic [IDX_W-1:0]    selIdx;
   logic [SUM_W-1:0]    coinSum;
   logic [2:0]          pickCode;
   logic [CREDIT_W-1:0] pickVal, changeRem;
   logic [NUM_SLOTS-1:0] affordMask, soldOutMask;

   change_picker #(.CREDIT_W(CREDIT_W)) uPicker (
      .amount   (credit),
      .coinCode (pickCode),
      .coinVal  (pickVal)
   );

   // Encode the one-hot select into a slot index.
   always_comb begin
      selIdx = '0;
      for (int i = 0; i < NUM_SLOTS; i++)
         if (bus.select[i]) selIdx = IDX_W'(i);
   end

   // IDLE command decode. Cancel outranks select, and a coin arriving with
   // either command asserted is bounced rather than credited.
   always_comb begin
      isIdle     = (state == ST_IDLE);
      selOneHot  = $onehot(bus.select);
      selAfford  = (stock[selIdx] != '0) && (price[selIdx] <= credit);
      cmdSel     = isIdle && !bus.cancel && selOneHot;
      cancelGo   = isIdle && bus.cancel && (credit != '0);
      vendGo     = cmdSel && selAfford;
      showPrice  = cmdSel && !selAfford;
      coinSum    = SUM_W'(credit) + SUM_W'(coinValue(bus.coinCode));
      coinAccept = isIdle && bus.coinValid && !bus.cancel && !selOneHot &&
                   coinIsValid(bus.coinCode) && (coinSum <= SUM_W'(MAX_CREDIT));
      cfgGo      = isIdle && bus.cfgWe && (credit == '0) &&
                   (int'(bus.cfgAddr) < NUM_SLOTS);
      changeRem  = credit - pickVal;
   end

   // Per-slot status masks.
   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         soldOutMask[i] = (stock[i] == '0);
         affordMask[i]  = (stock[i] != '0) && (price[i] <= credit);
      end
   end

   // Main FSM with slot table, credit and registered pulse outputs. A
   // leftover below 5c (possible only with non-multiple-of-5 prices) cannot
   // be paid out and is dropped instead of entering CHANGE.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state       <= ST_IDLE;
         credit      <= '0;
         price       <= '0;
         stock       <= '0;
         holdCnt     <= '0;
         dispIsPrice <= 1'b0;
         dispPrice   <= '0;
         vendValid   <= 1'b0;
         vendSlot    <= '0;
         coinReject  <= 1'b0;
      end else begin
         vendValid  <= 1'b0;
         coinReject <= bus.coinValid && !coinAccept;

         if (showPrice) begin
            dispIsPrice <= 1'b1;
            dispPrice   <= price[selIdx];
            holdCnt     <= HOLD_W'(PRICE_HOLD - 1);
         end else if (coinAccept || vendGo || cancelGo) begin
            dispIsPrice <= 1'b0;
            holdCnt     <= '0;
         end else if (dispIsPrice) begin
            if (holdCnt == '0) dispIsPrice <= 1'b0;
            else               holdCnt     <= holdCnt - 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (cfgGo) begin
                  price[bus.cfgAddr] <= bus.cfgPrice;
                  stock[bus.cfgAddr] <= bus.cfgStock;
               end
               if (cancelGo) begin
                  if (credit >= FIVE) state  <= ST_CHANGE;
                  else                credit <= '0;
               end else if (vendGo) begin
                  state         <= ST_VEND;
                  vendValid     <= 1'b1;
                  vendSlot      <= selIdx;
                  stock[selIdx] <= stock[selIdx] - STOCK_W'(1);
                  credit        <= credit - price[selIdx];
               end else if (coinAccept) begin
                  credit <= coinSum[CREDIT_W-1:0];
               end
            end
            ST_VEND: begin
               if (credit >= FIVE) state <= ST_CHANGE;
               else begin
                  credit <= '0;
                  state  <= ST_IDLE;
               end
            end
            ST_CHANGE: begin
               if (bus.changeAck) begin
                  if (changeRem >= FIVE) credit <= changeRem;
                  else begin
                     credit <= '0;
                     state  <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.credit      = credit;
   assign bus.dispValue   = dispIsPrice ? dispPrice : credit;
   assign bus.dispIsPrice = dispIsPrice;
   assign bus.affordMask  = affordMask;
   assign bus.soldOutMask = soldOutMask;
   assign bus.vendValid   = vendValid;
   assign bus.vendSlot    = vendSlot;
   assign bus.changeValid = (state == ST_CHANGE);
   assign bus.changeCoin  = pickCode;
   assign bus.coinReject  = coinReject;
   assign bus.busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_vending_controller.sv
// Directed bench for vending_controller: a per-cycle vector table for the
// vend/change/credit-ceiling flows plus hand sequences for price hold,
// stalled change return, sold-out reselect and reset during CHANGE.
module tb_vending_controller;

   logic clk = 1'b0;
   logic resetN = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   vending_controller_if #(.NUM_SLOTS(9), .CREDIT_W(12), .STOCK_W(4)) bus ();

   vending_controller #(
      .NUM_SLOTS(9), .CREDIT_W(12), .STOCK_W(4),
      .MAX_CREDIT(1000), .PRICE_HOLD(8)
   ) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus)
   );

   typedef struct {
      logic        cv;
      logic [2:0]  cc;
      logic [8:0]  sel;
      logic        can;
      logic        ack;
      logic [11:0] eCredit;
      logic        eVend;
      logic [3:0]  eSlot;
      logic        eChg;
      logic [2:0]  eCoin;
      logic        eRej;
      logic        eBusy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input int cv, input int cc, input int sel,
                               input int can, input int ack, input int cr,
                               input int vend, input int slot, input int chg,
                               input int coin, input int rej, input int busy);
      vec_t r;
      r.cv = cv[0];  r.cc = cc[2:0];  r.sel = sel[8:0];  r.can = can[0];
      r.ack = ack[0];  r.eCredit = cr[11:0];  r.eVend = vend[0];
      r.eSlot = slot[3:0];  r.eChg = chg[0];  r.eCoin = coin[2:0];
      r.eRej = rej[0];  r.eBusy = busy[0];
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic cv, input logic [2:0] cc, input logic [8:0] sel,
                       input logic can, input logic ack);
      bus.coinValid = cv;  bus.coinCode = cc;  bus.select = sel;
      bus.cancel = can;    bus.changeAck = ack;
      @(posedge clk);
      #1;
      bus.coinValid = 1'b0;  bus.select = '0;  bus.cancel = 1'b0;  bus.changeAck = 1'b0;
   endtask

   task automatic idle();
      step(1'b0, 3'd0, 9'h0, 1'b0, 1'b0);
   endtask

   task automatic coin(input logic [2:0] cc);
      step(1'b1, cc, 9'h0, 1'b0, 1'b0);
   endtask

   task automatic cfg(input logic [3:0] addr, input logic [11:0] pr, input logic [3:0] st);
      bus.cfgWe = 1'b1;  bus.cfgAddr = addr;  bus.cfgPrice = pr;  bus.cfgStock = st;
      @(posedge clk);
      #1;
      bus.cfgWe = 1'b0;
   endtask

   initial begin
      int n;
      bus.coinValid = 1'b0;  bus.coinCode = '0;  bus.select = '0;  bus.cancel = 1'b0;
      bus.cfgWe = 1'b0;  bus.cfgAddr = '0;  bus.cfgPrice = '0;  bus.cfgStock = '0;
      bus.changeAck = 1'b0;

      // Reset state
      #12;
      check("rst_credit",  32'(bus.credit), 32'd0);
      check("rst_busy",    32'(bus.busy), 32'd0);
      check("rst_vend",    32'(bus.vendValid), 32'd0);
      check("rst_chg",     32'(bus.changeValid), 32'd0);
      check("rst_rej",     32'(bus.coinReject), 32'd0);
      check("rst_isPrice", 32'(bus.dispIsPrice), 32'd0);
      check("rst_soldOut", 32'(bus.soldOutMask), 32'h1FF);
      check("rst_afford",  32'(bus.affordMask), 32'd0);
      @(negedge clk);
      resetN = 1'b1;

      cfg(4'd0, 12'd65, 4'd2);
      cfg(4'd1, 12'd65, 4'd1);
      cfg(4'd2, 12'd30, 4'd3);
      cfg(4'd12, 12'd5, 4'd9);   // out-of-range address, no effect
      check("cfg_soldOut", 32'(bus.soldOutMask), 32'h1F8);

      //           cv cc sel    can ack credit vend slot chg coin rej busy
      vecs.push_back(mk(1, 2, 0,     0, 0,  25, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 2, 0,     0, 0,  50, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0,     0, 0,  60, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0,     0, 0,  65, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 9'h1,  0, 0,   0, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0,     0, 0,   0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 4, 0,     0, 0, 100, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 9'h1,  0, 0,  35, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0,     0, 0,  35, 0, 0, 1, 2, 0, 1));
      vecs.push_back(mk(0, 0, 0,     0, 1,  10, 0, 0, 1, 1, 0, 1));
      vecs.push_back(mk(0, 0, 0,     0, 1,   0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 5, 0,     0, 0, 500, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 4, 0,     0, 0, 600, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 4, 0,     0, 0, 700, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 4, 0,     0, 0, 800, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 4, 0,     0, 0, 900, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 3, 0,     0, 0, 950, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 2, 0,     0, 0, 975, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0,     0, 0, 985, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0,     0, 0, 995, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0,     0, 0, 995, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0,     0, 0,1000, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 7, 0,     0, 0,1000, 0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0,     1, 0,1000, 0, 0, 1, 4, 1, 1));
      vecs.push_back(mk(1, 2, 0,     0, 0,1000, 0, 0, 1, 4, 1, 1));

      foreach (vecs[i]) begin
         step(vecs[i].cv, vecs[i].cc, vecs[i].sel, vecs[i].can, vecs[i].ack);
         check($sformatf("v%0d_credit", i),  32'(bus.credit), 32'(vecs[i].eCredit));
         check($sformatf("v%0d_disp", i),    32'(bus.dispValue), 32'(vecs[i].eCredit));
         check($sformatf("v%0d_isPrice", i), 32'(bus.dispIsPrice), 32'd0);
         check($sformatf("v%0d_vend", i),    32'(bus.vendValid), 32'(vecs[i].eVend));
         check($sformatf("v%0d_chg", i),     32'(bus.changeValid), 32'(vecs[i].eChg));
         check($sformatf("v%0d_rej", i),     32'(bus.coinReject), 32'(vecs[i].eRej));
         check($sformatf("v%0d_busy", i),    32'(bus.busy), 32'(vecs[i].eBusy));
         if (vecs[i].eVend) check($sformatf("v%0d_slot", i), 32'(bus.vendSlot), 32'(vecs[i].eSlot));
         if (vecs[i].eChg)  check($sformatf("v%0d_coin", i), 32'(bus.changeCoin), 32'(vecs[i].eCoin));
      end

      // Drain the 1000c cancel: ten 100c coins.
      for (int k = 1; k <= 10; k++) begin
         step(1'b0, 3'd0, 9'h0, 1'b0, 1'b1);
         check($sformatf("drain%0d_credit", k), 32'(bus.credit), 32'(1000 - 100 * k));
         check($sformatf("drain%0d_chg", k), 32'(bus.changeValid), (k < 10) ? 32'd1 : 32'd0);
      end

      // Price hold: credit 20, slot1 (65) unaffordable; reselect restarts hold.
      coin(3'd1);
      coin(3'd1);
      step(1'b0, 3'd0, 9'h2, 1'b0, 1'b0);
      check("hold_isPrice", 32'(bus.dispIsPrice), 32'd1);
      check("hold_disp",    32'(bus.dispValue), 32'd65);
      check("hold_credit",  32'(bus.credit), 32'd20);
      check("hold_noVend",  32'(bus.vendValid), 32'd0);
      idle(); idle(); idle();
      step(1'b0, 3'd0, 9'h2, 1'b0, 1'b0);
      n = (bus.dispIsPrice === 1'b1) ? 1 : 0;
      for (int c = 0; c < 30 && bus.dispIsPrice === 1'b1; c++) begin
         idle();
         if (bus.dispIsPrice === 1'b1) n++;
      end
      check("hold_cycles",   32'(n), 32'd8);
      check("hold_revert",   32'(bus.dispValue), 32'd20);
      step(1'b0, 3'd0, 9'h2, 1'b0, 1'b0);
      coin(3'd0);
      check("hold_coinClr", 32'(bus.dispIsPrice), 32'd0);
      check("hold_coinDisp", 32'(bus.dispValue), 32'd25);

      // Credit 40, cancel with ack stalled: 25 held, then 10, then 5.
      coin(3'd1);
      coin(3'd0);
      check("c40_credit", 32'(bus.credit), 32'd40);
      step(1'b0, 3'd0, 9'h0, 1'b1, 1'b0);
      for (int c = 0; c < 5; c++) begin
         check($sformatf("stall%0d", c), 32'({bus.changeValid, bus.changeCoin}), 32'({1'b1, 3'd2}));
         idle();
      end
      check("stall_credit", 32'(bus.credit), 32'd40);
      step(1'b0, 3'd0, 9'h0, 1'b0, 1'b1);
      check("c40_ack1_credit", 32'(bus.credit), 32'd15);
      check("c40_ack1_coin",   32'(bus.changeCoin), 32'd1);
      step(1'b0, 3'd0, 9'h0, 1'b0, 1'b1);
      check("c40_ack2_credit", 32'(bus.credit), 32'd5);
      check("c40_ack2_coin",   32'(bus.changeCoin), 32'd0);
      step(1'b0, 3'd0, 9'h0, 1'b0, 1'b1);
      check("c40_done_credit", 32'(bus.credit), 32'd0);
      check("c40_done_chg",    32'(bus.changeValid), 32'd0);
      check("c40_done_busy",   32'(bus.busy), 32'd0);

      // Sell out slot1, reselect, blocked cfg, reset during CHANGE.
      coin(3'd3); coin(3'd1); coin(3'd0);
      check("so_afford", 32'(bus.affordMask), 32'h006);
      step(1'b0, 3'd0, 9'h2, 1'b0, 1'b0);
      check("so_vend", 32'(bus.vendValid), 32'd1);
      check("so_slot", 32'(bus.vendSlot), 32'd1);
      idle();
      check("so_soldOut", 32'(bus.soldOutMask), 32'h1FB);
      coin(3'd4);
      cfg(4'd1, 12'd65, 4'd5);
      check("so_cfgBlocked", 32'(bus.soldOutMask), 32'h1FB);
      step(1'b0, 3'd0, 9'h2, 1'b0, 1'b0);
      check("so_noVend",  32'(bus.vendValid), 32'd0);
      check("so_busy",    32'(bus.busy), 32'd0);
      check("so_price",   32'(bus.dispValue), 32'd65);
      step(1'b0, 3'd0, 9'h0, 1'b1, 1'b0);
      check("so_chg",     32'(bus.changeValid), 32'd1);
      check("so_coin",    32'(bus.changeCoin), 32'd4);
      resetN = 1'b0;
      #2;
      check("mid_rst_credit",  32'(bus.credit), 32'd0);
      check("mid_rst_chg",     32'(bus.changeValid), 32'd0);
      check("mid_rst_busy",    32'(bus.busy), 32'd0);
      check("mid_rst_soldOut", 32'(bus.soldOutMask), 32'h1FF);
      @(negedge clk);
      resetN = 1'b1;
      idle();
      idle();
      check("post_rst_vend",   32'(bus.vendValid), 32'd0);
      check("post_rst_chg",    32'(bus.changeValid), 32'd0);
      check("post_rst_credit", 32'(bus.credit), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
